// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Holds the controller state encoding and the operation select values.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    MULT_ITER = 3'd2,
    DIV_ITER  = 3'd3,
    DIV_FIX   = 3'd4,
    WRITE     = 3'd5,
    DIV0      = 3'd6
  } state_e;

endpackage : mdu_pkg

// File: rtl/mdu_iter_counter.sv
// Iteration counter for the multiply/divide sequencer.
// Clears on request, counts when enabled and flags the final iteration (WIDTH-1).
module mdu_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST);

endmodule : mdu_iter_counter

// File: rtl/mult_div_sequencer.sv
// Multicycle controller for the iterative multiply/divide datapath: load, WIDTH
// shift steps, optional signed fix-up, then HI/LO write or divide-by-zero pulse.
module mult_div_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             divisor_zero,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic             busy,
  output logic             load_operands,
  output logic             mult_step,
  output logic             div_step,
  output logic             fix_sign_quot,
  output logic             fix_sign_rem,
  output logic             hi_write,
  output logic             lo_write,
  output logic             done,
  output logic             div_zero_exc,
  output logic [CNT_W-1:0] iter_count
);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   sign_a_q, sign_a_d;
  logic   sign_b_q, sign_b_d;
  logic   iter_last;
  logic   in_iter;

  assign in_iter = (state_q == MULT_ITER) || (state_q == DIV_ITER);

  // Count holds at WIDTH-1 on the final step so it never wraps.
  mdu_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == LOAD),
    .en_i    (in_iter && !iter_last),
    .count_o (iter_count),
    .last_o  (iter_last)
  );

  always_comb begin
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    if (state_q == IDLE && start) begin
      op_d = op;
    end
    if (state_q == LOAD) begin
      sign_a_d = sign_a;
      sign_b_d = sign_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD: begin
        if (op_q == OP_DIV && divisor_zero) state_d = DIV0;
        else if (op_q == OP_DIV)            state_d = DIV_ITER;
        else                                state_d = MULT_ITER;
      end
      MULT_ITER: if (iter_last) state_d = WRITE;
      DIV_ITER:  if (iter_last) state_d = DIV_FIX;
      DIV_FIX:   state_d = WRITE;
      WRITE:     state_d = IDLE;
      DIV0:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    load_operands = (state_q == LOAD);
    mult_step     = (state_q == MULT_ITER);
    div_step      = (state_q == DIV_ITER);
    fix_sign_quot = 1'b0;
    fix_sign_rem  = 1'b0;
    hi_write      = (state_q == WRITE);
    lo_write      = (state_q == WRITE);
    done          = (state_q == WRITE);
    div_zero_exc  = (state_q == DIV0);
    if (state_q == DIV_FIX) begin
      fix_sign_quot = sign_a_q ^ sign_b_q;
      fix_sign_rem  = sign_a_q;
    end
  end

endmodule : mult_div_sequencer

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: a WIDTH=32 and a WIDTH=4 instance share stimulus,
// checked each cycle against a latency-table model plus hand-computed literals.
module tb_mult_div_sequencer;

  localparam int MAXC = 2048;

  typedef struct packed {
    logic [9:0] o;     // {busy,load,mstep,dstep,fq,fr,hw,lw,done,dz}
    logic       ichk;
    logic [5:0] it;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, op, divisor_zero, sign_a, sign_b;

  logic       busy32, ld32, ms32, ds32, fq32, fr32, hw32, lw32, dn32, dz32;
  logic       busy4, ld4, ms4, ds4, fq4, fr4, hw4, lw4, dn4, dz4;
  logic [5:0] it32, it4;

  logic [9:0] act [2];
  logic [5:0] it_act [2];

  exp_t exp_tab [2][MAXC];
  int   cyc = 0;
  int   idle_from [2];
  int   load_edge [2];
  logic op_l [2];

  int   n_checks = 0;
  int   n_fail = 0;

  int   last_done [2], last_load [2], last_dz [2], dstep_cnt [2];
  logic last_fix_q [2], last_fix_r [2], prev_fq [2], prev_fr [2];

  always #5 clk = ~clk;

  mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor_zero(divisor_zero),
    .sign_a(sign_a), .sign_b(sign_b), .busy(busy32), .load_operands(ld32),
    .mult_step(ms32), .div_step(ds32), .fix_sign_quot(fq32), .fix_sign_rem(fr32),
    .hi_write(hw32), .lo_write(lw32), .done(dn32), .div_zero_exc(dz32),
    .iter_count(it32)
  );

  mult_div_sequencer #(.WIDTH(4), .CNT_W(6)) dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor_zero(divisor_zero),
    .sign_a(sign_a), .sign_b(sign_b), .busy(busy4), .load_operands(ld4),
    .mult_step(ms4), .div_step(ds4), .fix_sign_quot(fq4), .fix_sign_rem(fr4),
    .hi_write(hw4), .lo_write(lw4), .done(dn4), .div_zero_exc(dz4),
    .iter_count(it4)
  );

  assign act[0] = {busy32, ld32, ms32, ds32, fq32, fr32, hw32, lw32, dn32, dz32};
  assign act[1] = {busy4, ld4, ms4, ds4, fq4, fr4, hw4, lw4, dn4, dz4};
  assign it_act[0] = it32;
  assign it_act[1] = it4;

  function automatic logic [9:0] mk(logic b, logic l, logic m, logic d, logic q,
                                    logic r, logic h, logic w, logic n, logic z);
    return {b, l, m, d, q, r, h, w, n, z};
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, actual, required);
    end
  endtask

  // Model: an accepted start schedules the whole operation's output timeline.
  task automatic model_edge(int i);
    int n;
    int w;
    n = cyc;
    w = (i == 0) ? 32 : 4;
    if (!reset) begin
      for (int k = n; k < MAXC; k++) exp_tab[i][k] = '0;
      exp_tab[i][n].ichk = 1'b1;
      idle_from[i] = n;
      load_edge[i] = -1;
    end else if (n == load_edge[i]) begin
      if (op_l[i] && divisor_zero) begin
        exp_tab[i][n].o = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle_from[i] = n + 1;
      end else begin
        for (int k = 0; k < w; k++) begin
          exp_tab[i][n+k].o    = mk(1, 0, !op_l[i], op_l[i], 0, 0, 0, 0, 0, 0);
          exp_tab[i][n+k].ichk = 1'b1;
          exp_tab[i][n+k].it   = 6'(k);
        end
        if (op_l[i]) begin
          exp_tab[i][n+w].o = mk(1, 0, 0, 0, sign_a ^ sign_b, sign_a, 0, 0, 0, 0);
          w = w + 1;
        end
        exp_tab[i][n+w].o = mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        idle_from[i] = n + w + 1;
      end
    end else if (idle_from[i] <= n - 1 && start) begin
      op_l[i] = op;
      exp_tab[i][n].o = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle_from[i] = MAXC;
      load_edge[i] = n + 1;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_edge(0);
    model_edge(1);
  end

  // Compare process: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("outputs_w%0d", (i == 0) ? 32 : 4), 32'(act[i]), 32'(exp_tab[i][cyc].o));
        if (exp_tab[i][cyc].ichk)
          check($sformatf("iter_w%0d", (i == 0) ? 32 : 4), 32'(it_act[i]), 32'(exp_tab[i][cyc].it));
        if (act[i][1]) begin
          last_done[i]  = cyc;
          last_fix_q[i] = prev_fq[i];
          last_fix_r[i] = prev_fr[i];
        end
        if (act[i][8]) last_load[i] = cyc;
        if (act[i][0]) last_dz[i] = cyc;
        if (act[i][6]) dstep_cnt[i]++;
        prev_fq[i] = act[i][5];
        prev_fr[i] = act[i][4];
      end
    end
  end

  task automatic pulse_start(input logic op_v, output int s);
    start = 1'b1;
    op    = op_v;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int s;
    int saved;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < MAXC; k++) exp_tab[i][k] = '0;
      idle_from[i] = 0;  load_edge[i] = -1;  op_l[i] = 1'b0;
      last_done[i] = -1; last_load[i] = -1;  last_dz[i] = -1;  dstep_cnt[i] = 0;
      last_fix_q[i] = 1'b0; last_fix_r[i] = 1'b0; prev_fq[i] = 1'b0; prev_fr[i] = 1'b0;
    end
    reset = 1'b0; start = 1'b0; op = 1'b0;
    divisor_zero = 1'b0; sign_a = 1'b0; sign_b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // MULT: load at t+1, write at t+WIDTH+2
    pulse_start(1'b0, s);
    repeat (40) @(negedge clk);
    check("mult_load_w32", last_load[0], s);
    check("mult_done_w32", last_done[0], s + 33);
    check("mult_done_w4", last_done[1], s + 5);

    // DIV, dividend negative; op flips right after acceptance
    sign_a = 1'b1; sign_b = 1'b0;
    pulse_start(1'b1, s);
    op = 1'b0;
    repeat (40) @(negedge clk);
    check("div_done_w32", last_done[0], s + 34);
    check("div_fixq_w32", last_fix_q[0], 1);
    check("div_fixr_w32", last_fix_r[0], 1);

    // Divide by zero, then a MULT with divisor_zero still high
    divisor_zero = 1'b1;
    saved = last_done[0];
    pulse_start(1'b1, s);
    repeat (6) @(negedge clk);
    check("div0_pulse_w32", last_dz[0], s + 1);
    check("div0_pulse_w4", last_dz[1], s + 1);
    check("div0_no_done_w32", last_done[0], saved);
    pulse_start(1'b0, s);
    repeat (40) @(negedge clk);
    check("mult_dz_ignored_w32", last_done[0], s + 33);
    divisor_zero = 1'b0;

    // Reset in the middle of a MULT at iteration 15
    saved = last_done[0];
    pulse_start(1'b0, s);
    while (cyc < s + 16) @(negedge clk);
    check("iter_before_abort_w32", it32, 15);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done_w32", last_done[0], saved);
    pulse_start(1'b0, s);
    repeat (40) @(negedge clk);
    check("after_abort_done_w32", last_done[0], s + 33);

    // start re-pulsed during DIV_ITER and held through WRITE
    sign_a = 1'b1; sign_b = 1'b1;
    pulse_start(1'b1, s);
    op = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    while (cyc < s + 40) @(negedge clk);
    start = 1'b0;
    check("b2b_first_done_w32", last_done[0], s + 34);
    check("b2b_first_fixq_w32", last_fix_q[0], 0);
    check("b2b_second_load_w32", last_load[0], s + 36);
    repeat (50) @(negedge clk);
    check("b2b_second_done_w32", last_done[0], s + 69);

    // WIDTH=4 DIV with both operands negative
    saved = dstep_cnt[1];
    pulse_start(1'b1, s);
    repeat (12) @(negedge clk);
    check("w4_div_steps", dstep_cnt[1] - saved, 4);
    check("w4_div_done", last_done[1], s + 6);
    check("w4_div_fixq", last_fix_q[1], 0);
    check("w4_div_fixr", last_fix_r[1], 1);
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mult_div_sequencer
